// File: rtl/cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_step_ctrl
//
// Run/step sequencer for the CPU core clock. It produces a one-cycle clock
// enable (cpu_ce) for the core from the board clock. The enable source depends
// on the selected mode: halt, free-run at a programmable divide ratio,
// single-step from a push button, or run exactly N cycles. An optional PC
// breakpoint can freeze the core.
//
// Optional feature macro: CPU_STEP_CTRL_BP_EN
//   defined     -> PC breakpoint, BREAK state and skip-once logic are built.
//   not defined -> bp_en / bp_addr / pc are ignored, bp_hit is tied to 0 and
//                  BREAK can never be entered.
//
// Ports
//   raw_clk    in   board clock (the only clock)
//   rst        in   asynchronous reset, active low
//   mode       in   2'b00 halt, 2'b01 free-run, 2'b10 step, 2'b11 run-N
//   div        in   raw_clk ticks per cpu_ce in free-run / run-N (0 acts as 1)
//   step_btn   in   raw asynchronous step push button
//   start      in   one-cycle pulse, loads run_cnt in run-N mode
//   run_cnt    in   cycle count for run-N
//   bp_en      in   breakpoint enable
//   bp_addr    in   breakpoint PC
//   pc         in   current core PC
//   cpu_ce     out  core clock enable, one raw_clk cycle wide
//   halted     out  no cpu_ce can be issued without new input
//   bp_hit     out  high while stopped at a breakpoint
//   done       out  one-cycle pulse when run-N count reaches 0
//   remaining  out  run-N cycles still to issue
// -----------------------------------------------------------------------------
module cpu_step_ctrl #(
  parameter int DIV_WIDTH = 32,
  parameter int CNT_WIDTH = 16,
  parameter int PC_WIDTH  = 16
) (
  input  logic                 raw_clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 step_btn,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] run_cnt,
  input  logic                 bp_en,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic                 cpu_ce,
  output logic                 halted,
  output logic                 bp_hit,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] remaining
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FREE  = 3'd1,
    STEP  = 3'd2,
    RUNN  = 3'd3,
    BREAK = 3'd4
  } state_t;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_FREE = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_RUNN = 2'b11;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_reg, state_next;
  logic                   cpu_ce_reg, ce_next;
  logic                   halted_reg;
  logic                   done_reg, done_next;
  logic [CNT_WIDTH-1:0]   remaining_reg, remaining_next;
  logic [DIV_WIDTH-1:0]   divcnt_reg, divcnt_next;
  logic                   bp_skip_reg, bp_skip_next;

  // Step button: two synchronizer flops, then a third flop for edge detect.
  logic step_sync1_reg, step_sync2_reg, step_prev_reg;
  logic step_edge;
  assign step_edge = step_sync2_reg & ~step_prev_reg;

  // Divider terminal count. Using >= instead of == means lowering div below
  // the current count ticks on the next cycle instead of wrapping around.
  logic [DIV_WIDTH-1:0] div_last;
  logic                 tick;
  assign div_last = (div == '0) ? '0 : (div - DIV_ONE);
  assign tick     = (divcnt_reg >= div_last);

  logic bp_match;
`ifdef CPU_STEP_CTRL_BP_EN
  // bp_skip lets the core leave a breakpoint address without re-triggering.
  assign bp_match = bp_en && (pc == bp_addr) && !bp_skip_reg;

  function automatic state_t mode_state(input logic [1:0] m);
    case (m)
      MODE_FREE: mode_state = FREE;
      MODE_STEP: mode_state = STEP;
      MODE_RUNN: mode_state = RUNN;
      default:   mode_state = IDLE;
    endcase
  endfunction
`else
  assign bp_match = 1'b0;
  logic unused_bp;
  assign unused_bp = bp_en ^ (^bp_addr) ^ (^pc) ^ bp_skip_next;
`endif

  // Next-state logic. Branch order inside each state encodes the precedence:
  // mode change, then breakpoint, then start, then tick / step edge.
  always_comb begin
    state_next     = state_reg;
    ce_next        = 1'b0;
    done_next      = 1'b0;
    remaining_next = remaining_reg;
    bp_skip_next   = bp_skip_reg;

    case (state_reg)
      IDLE: begin
        case (mode)
          MODE_FREE: state_next = FREE;
          MODE_STEP: state_next = STEP;
          MODE_RUNN: begin
            if (start) begin
              if (run_cnt == '0) begin
                remaining_next = '0;
                done_next      = 1'b1;
              end else begin
                remaining_next = run_cnt;
                state_next     = RUNN;
              end
            end
          end
          default: state_next = IDLE;
        endcase
      end

      FREE: begin
        if (mode != MODE_FREE) begin
          state_next = IDLE;
        end else if (tick) begin
          if (bp_match) begin
            state_next = BREAK;
          end else begin
            ce_next      = 1'b1;
            bp_skip_next = 1'b0;
          end
        end
      end

      STEP: begin
        if (mode != MODE_STEP) begin
          state_next = IDLE;
        end else if (step_edge) begin
          if (bp_match) begin
            state_next = BREAK;
          end else begin
            ce_next      = 1'b1;
            bp_skip_next = 1'b0;
          end
        end
      end

      RUNN: begin
        if (mode != MODE_RUNN) begin
          state_next = IDLE;              // remaining is held for inspection
        end else if (tick && bp_match) begin
          state_next = BREAK;             // no decrement on a suppressed ce
        end else if (start) begin
          if (run_cnt == '0) begin
            remaining_next = '0;
            done_next      = 1'b1;
            state_next     = IDLE;
          end else begin
            remaining_next = run_cnt;
          end
        end else if (tick) begin
          ce_next        = 1'b1;
          bp_skip_next   = 1'b0;
          remaining_next = remaining_reg - CNT_ONE;
          if (remaining_reg == CNT_ONE) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end

`ifdef CPU_STEP_CTRL_BP_EN
      BREAK: begin
        if (mode == MODE_HALT) begin
          state_next = IDLE;
        end else if (start) begin
          // Resume without a ce; skip the breakpoint the core is sitting on.
          bp_skip_next = 1'b1;
          state_next   = mode_state(mode);
          if (mode == MODE_RUNN) begin
            if (run_cnt == '0) begin
              remaining_next = '0;
              done_next      = 1'b1;
              state_next     = IDLE;
            end else begin
              remaining_next = run_cnt;
            end
          end
        end else if (step_edge) begin
          // Single ce past the breakpoint; skip stays armed until the next ce.
          ce_next      = 1'b1;
          bp_skip_next = 1'b1;
          state_next   = mode_state(mode);
          if ((mode == MODE_RUNN) && (remaining_reg != '0)) begin
            remaining_next = remaining_reg - CNT_ONE;
            if (remaining_reg == CNT_ONE) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end
          end
        end
      end
`endif

      default: state_next = IDLE;
    endcase

    // Divider runs only in the counting states and restarts on any state change.
    divcnt_next = '0;
    if ((state_next == state_reg) && ((state_reg == FREE) || (state_reg == RUNN))) begin
      divcnt_next = tick ? '0 : (divcnt_reg + DIV_ONE);
    end
  end

`ifdef CPU_STEP_CTRL_BP_EN
  logic bp_hit_reg;
  assign bp_hit = bp_hit_reg;
`else
  assign bp_hit = 1'b0;
`endif

  always_ff @(posedge raw_clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cpu_ce_reg     <= 1'b0;
      halted_reg     <= 1'b1;
      done_reg       <= 1'b0;
      remaining_reg  <= '0;
      divcnt_reg     <= '0;
      bp_skip_reg    <= 1'b0;
      step_sync1_reg <= 1'b0;
      step_sync2_reg <= 1'b0;
      step_prev_reg  <= 1'b0;
`ifdef CPU_STEP_CTRL_BP_EN
      bp_hit_reg     <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      cpu_ce_reg     <= ce_next;
      halted_reg     <= (state_next == IDLE) || (state_next == STEP) || (state_next == BREAK);
      done_reg       <= done_next;
      remaining_reg  <= remaining_next;
      divcnt_reg     <= divcnt_next;
      step_sync1_reg <= step_btn;
      step_sync2_reg <= step_sync1_reg;
      step_prev_reg  <= step_sync2_reg;
`ifdef CPU_STEP_CTRL_BP_EN
      bp_skip_reg    <= bp_skip_next;
      bp_hit_reg     <= (state_next == BREAK);
`else
      bp_skip_reg    <= 1'b0;
`endif
    end
  end

  assign cpu_ce    = cpu_ce_reg;
  assign halted    = halted_reg;
  assign done      = done_reg;
  assign remaining = remaining_reg;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_step_ctrl
//
// Directed bench for cpu_step_ctrl: free-run, divider edge cases, single-step,
// run-N (including a zero count), abort of run-N, asynchronous reset and the
// PC breakpoint (expectations follow CPU_STEP_CTRL_BP_EN). A small core model
// advances pc on every cpu_ce so the breakpoint can be reached.
// -----------------------------------------------------------------------------
module tb_cpu_step_ctrl;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int PW = 16;

  logic          raw_clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [DW-1:0] div;
  logic          step_btn;
  logic          start;
  logic [CW-1:0] run_cnt;
  logic          bp_en;
  logic [PW-1:0] bp_addr;
  logic [PW-1:0] pc;
  logic          cpu_ce;
  logic          halted;
  logic          bp_hit;
  logic          done;
  logic [CW-1:0] remaining;

  int n_cmp = 0;
  int n_bad = 0;
  int ce_total = 0;
  int c0;
  logic pc_clear = 1'b1;

  always #5 raw_clk = ~raw_clk;

  cpu_step_ctrl #(.DIV_WIDTH(DW), .CNT_WIDTH(CW), .PC_WIDTH(PW)) dut (
    .raw_clk   (raw_clk),
    .rst       (rst),
    .mode      (mode),
    .div       (div),
    .step_btn  (step_btn),
    .start     (start),
    .run_cnt   (run_cnt),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .cpu_ce    (cpu_ce),
    .halted    (halted),
    .bp_hit    (bp_hit),
    .done      (done),
    .remaining (remaining)
  );

  // Core model: the PC advances as soon as a cpu_ce is seen, so each ce
  // candidate the controller evaluates sees the PC of the next instruction.
  always @(negedge raw_clk) begin
    if (pc_clear) pc <= '0;
    else if (cpu_ce) pc <= pc + 16'd1;
    if (cpu_ce) ce_total <= ce_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge raw_clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; mode = 2'b00; div = 32'd4; step_btn = 1'b0; start = 1'b0;
    run_cnt = '0; bp_en = 1'b0; bp_addr = '0;

    // Reset state
    cycles(2);
    check("rst_ce",        32'(cpu_ce),    32'd0);
    check("rst_halted",    32'(halted),    32'd1);
    check("rst_bp_hit",    32'(bp_hit),    32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_remaining", 32'(remaining), 32'd0);
    rst = 1'b1; pc_clear = 1'b0;
    cycles(1);
    $display("reset: ce=%0d halted=%0d", cpu_ce, halted);

    // Free-run, div=4: first ce 4 cycles after entering FREE, then every 4
    mode = 2'b01; div = 32'd4;
    cycles(1);
    check("free_halted",      32'(halted), 32'd0);
    check("free_enter_ce",    32'(cpu_ce), 32'd0);
    cycles(3);
    check("free_before_first", 32'(cpu_ce), 32'd0);
    cycles(1);
    check("free_first_ce",    32'(cpu_ce), 32'd1);
    cycles(3);
    check("free_gap",         32'(cpu_ce), 32'd0);
    cycles(1);
    check("free_second_ce",   32'(cpu_ce), 32'd1);
    c0 = ce_total;
    cycles(16);
    check("free_period4_count", 32'(ce_total - c0), 32'd4);
    $display("free div=4: %0d ce in 16 cycles", ce_total - c0);

    // div=0 behaves as div=1: ce every cycle
    div = 32'd0;
    cycles(1);
    check("div0_ce", 32'(cpu_ce), 32'd1);
    c0 = ce_total;
    cycles(5);
    check("div0_count", 32'(ce_total - c0), 32'd5);
    $display("free div=0: %0d ce in 5 cycles", ce_total - c0);

    // Lowering div below the running count ticks on the next cycle
    div = 32'd8;
    cycles(5);
    check("div8_wait", 32'(cpu_ce), 32'd0);
    div = 32'd2;
    cycles(1);
    check("div_lowered_tick", 32'(cpu_ce), 32'd1);
    $display("div lowered 8->2 at count 5: ce=%0d", cpu_ce);

    mode = 2'b00;
    cycles(1);
    check("free_to_idle_halted", 32'(halted), 32'd1);
    check("free_to_idle_ce",     32'(cpu_ce), 32'd0);

    // Single step: held button gives one ce, 3 cycles after the rise
    mode = 2'b10;
    cycles(1);
    check("step_mode_halted", 32'(halted), 32'd1);
    cycles(1);
    step_btn = 1'b1;
    cycles(2);
    check("step_latency_2", 32'(cpu_ce), 32'd0);
    cycles(1);
    check("step_ce_3",      32'(cpu_ce), 32'd1);
    check("step_halted",    32'(halted), 32'd1);
    c0 = ce_total;
    cycles(17);
    check("step_held_single", 32'(ce_total - c0), 32'd1);
    $display("step: held 20 cycles -> %0d ce", ce_total - c0);
    step_btn = 1'b0;
    cycles(3);

    // Run-N: div=2, run_cnt=5
    mode = 2'b11; div = 32'd2;
    cycles(1);
    check("runn_idle_halted", 32'(halted), 32'd1);
    start = 1'b1; run_cnt = 16'd5;
    cycles(1);
    start = 1'b0;
    check("runn_loaded",  32'(remaining), 32'd5);
    check("runn_halted",  32'(halted),    32'd0);
    check("runn_load_ce", 32'(cpu_ce),    32'd0);
    c0 = ce_total;
    cycles(1);
    check("runn_first_wait", 32'(cpu_ce), 32'd0);
    cycles(1);
    check("runn_first_ce",   32'(cpu_ce),    32'd1);
    check("runn_rem4",       32'(remaining), 32'd4);
    check("runn_not_done",   32'(done),      32'd0);
    cycles(8);
    check("runn_last_ce",    32'(cpu_ce),    32'd1);
    check("runn_done",       32'(done),      32'd1);
    check("runn_rem0",       32'(remaining), 32'd0);
    check("runn_end_halted", 32'(halted),    32'd1);
    cycles(1);
    check("runn_done_pulse", 32'(done), 32'd0);
    check("runn_count",      32'(ce_total - c0), 32'd5);
    $display("run-N 5: %0d ce, remaining=%0d", ce_total - c0, remaining);

    // Run-N with a zero count: done next cycle, no ce
    start = 1'b1; run_cnt = 16'd0;
    cycles(1);
    start = 1'b0;
    check("runn0_done",   32'(done),   32'd1);
    check("runn0_ce",     32'(cpu_ce), 32'd0);
    check("runn0_halted", 32'(halted), 32'd1);
    cycles(1);
    check("runn0_done_pulse", 32'(done), 32'd0);
    $display("run-N 0: done pulse, no ce");

    // Run-N 100 aborted at remaining=60
    div = 32'd1; run_cnt = 16'd100; start = 1'b1;
    cycles(1);
    start = 1'b0;
    check("abort_loaded", 32'(remaining), 32'd100);
    cycles(40);
    check("abort_rem60", 32'(remaining), 32'd60);
    mode = 2'b00;
    cycles(1);
    check("abort_rem_held", 32'(remaining), 32'd60);
    check("abort_ce",       32'(cpu_ce),    32'd0);
    check("abort_halted",   32'(halted),    32'd1);
    c0 = ce_total;
    cycles(5);
    check("abort_no_ce",    32'(ce_total - c0), 32'd0);
    check("abort_rem_still", 32'(remaining), 32'd60);
    $display("run-N abort: remaining=%0d", remaining);

    // Asynchronous reset mid-cycle while free-running
    mode = 2'b01;
    cycles(3);
    check("pre_rst_ce",  32'(cpu_ce),    32'd1);
    check("pre_rst_rem", 32'(remaining), 32'd60);
    #2;
    rst = 1'b0;
    #1;
    check("async_ce",        32'(cpu_ce),    32'd0);
    check("async_halted",    32'(halted),    32'd1);
    check("async_done",      32'(done),      32'd0);
    check("async_remaining", 32'(remaining), 32'd0);
    check("async_bp_hit",    32'(bp_hit),    32'd0);
    mode = 2'b00;
    cycles(1);
    check("rst_hold_ce", 32'(cpu_ce), 32'd0);
    rst = 1'b1;
    cycles(1);
    $display("async reset: ce=%0d remaining=%0d", cpu_ce, remaining);

    // Breakpoint scenario: free-run div=1, break at pc 0x10
    pc_clear = 1'b1;
    cycles(1);
    pc_clear = 1'b0;
    bp_en = 1'b1; bp_addr = 16'h0010; div = 32'd1; mode = 2'b01;
    cycles(31);
`ifdef CPU_STEP_CTRL_BP_EN
    check("bp_stop_ce",     32'(cpu_ce), 32'd0);
    check("bp_hit",         32'(bp_hit), 32'd1);
    check("bp_halted",      32'(halted), 32'd1);
    check("bp_pc",          32'(pc),     32'h10);
`else
    check("nobp_ce",        32'(cpu_ce), 32'd1);
    check("nobp_hit",       32'(bp_hit), 32'd0);
    check("nobp_halted",    32'(halted), 32'd0);
    check("nobp_pc",        32'(pc),     32'h1D);
`endif
    $display("breakpoint: pc=%0h bp_hit=%0d ce=%0d", pc, bp_hit, cpu_ce);
    step_btn = 1'b1;
    cycles(3);
    check("bp_step_ce",     32'(cpu_ce), 32'd1);
    check("bp_step_hit",    32'(bp_hit), 32'd0);
    check("bp_step_halted", 32'(halted), 32'd0);
    cycles(1);
    check("bp_resume_ce",   32'(cpu_ce), 32'd1);
`ifdef CPU_STEP_CTRL_BP_EN
    check("bp_step_pc",     32'(pc),     32'h11);
`else
    check("nobp_step_pc",   32'(pc),     32'h21);
`endif
    step_btn = 1'b0;
    cycles(10);
    check("bp_run_ce",      32'(cpu_ce), 32'd1);
    check("bp_run_hit",     32'(bp_hit), 32'd0);
`ifdef CPU_STEP_CTRL_BP_EN
    check("bp_run_pc",      32'(pc),     32'h1B);
`else
    check("nobp_run_pc",    32'(pc),     32'h2B);
`endif
    $display("after step: pc=%0h ce=%0d bp_hit=%0d", pc, cpu_ce, bp_hit);

    mode = 2'b00;
    cycles(2);
    check("final_halted", 32'(halted), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
